// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: pc, imem read, stall hold buffer, redirect
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instr_out
);

  logic [31:0] pc_reg;
  logic [31:0] iss_pc;
  logic        iss_valid;
  logic [31:0] hold_instr;
  logic        use_hold;

  // A fetch is issued whenever the stage is free to advance.
  assign imem_en      = ~stall & ~redirect_valid;
  assign imem_addr    = pc_reg;
  assign valid_out    = iss_valid;
  assign pc_out       = iss_pc;
  assign pc_plus4_out = iss_pc + 32'd4;
  // The memory only returns data for one cycle; during a stall the
  // captured copy keeps the presented word stable.
  assign instr_out    = use_hold ? hold_instr : imem_rdata;

  // Pipeline state: reset beats redirect, redirect beats stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      iss_pc     <= 32'd0;
      iss_valid  <= 1'b0;
      hold_instr <= 32'd0;
      use_hold   <= 1'b0;
    end else if (redirect_valid) begin
      pc_reg    <= {redirect_pc[31:2], 2'b00};
      iss_valid <= 1'b0;
      use_hold  <= 1'b0;
    end else if (stall) begin
      if (!use_hold) begin
        hold_instr <= imem_rdata;
        use_hold   <= 1'b1;
      end
    end else begin
      iss_pc    <= pc_reg;
      iss_valid <= 1'b1;
      pc_reg    <= pc_reg + 32'd4;
      use_hold  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        en0, en1;
  logic [31:0] addr0, addr1;
  logic [31:0] rdata0, rdata1;
  logic        v0, v1;
  logic [31:0] pc0, pc1, p40, p41, in0, in1;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(en0), .imem_addr(addr0), .imem_rdata(rdata0),
    .valid_out(v0), .pc_out(pc0), .pc_plus4_out(p40), .instr_out(in0)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(en1), .imem_addr(addr1), .imem_rdata(rdata1),
    .valid_out(v1), .pc_out(pc1), .pc_plus4_out(p41), .instr_out(in1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Synchronous memories; they drive garbage on cycles without a read.
  always @(posedge clk) begin
    rdata0 <= en0 ? mem_word(addr0) : ($urandom | 32'h8000_0000);
    rdata1 <= en1 ? mem_word(addr1) : ($urandom | 32'h8000_0000);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic pres0(input string tag, input logic [31:0] pc);
    check({tag, " valid"}, {31'd0, v0}, 32'd1);
    check({tag, " pc"}, pc0, pc);
    check({tag, " instr"}, in0, mem_word(pc));
    check({tag, " pc4"}, p40, pc + 32'd4);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

    // reset state
    cyc(1, 0, 0, 0);
    check("rst valid0", {31'd0, v0}, 32'd0);
    check("rst pc0", pc0, 32'd0);
    check("rst addr0", addr0, 32'd0);
    check("rst valid1", {31'd0, v1}, 32'd0);
    check("rst addr1", addr1, 32'hFFFF_FFF8);

    // free run
    cyc(0, 0, 0, 0);
    check("c1 en", {31'd0, en0}, 32'd1);
    check("c1 valid", {31'd0, v0}, 32'd0);
    check("c1 addr", addr0, 32'd0);
    cyc(0, 0, 0, 0);
    pres0("c2", 32'h0);
    check("w2 pc", pc1, 32'hFFFF_FFF8);
    check("w2 instr", in1, 32'h4FFF_FFFE);
    check("w2 pc4", p41, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    pres0("c3", 32'h4);
    check("w3 pc", pc1, 32'hFFFF_FFFC);
    check("w3 instr", in1, 32'h4FFF_FFFF);
    check("w3 pc4", p41, 32'h0);

    // 3-cycle stall while pc 8 is presented
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0);
      pres0($sformatf("stall%0d", k), 32'h8);
      check($sformatf("stall%0d en", k), {31'd0, en0}, 32'd0);
      check($sformatf("w stall%0d pc", k), pc1, 32'h0);
      check($sformatf("w stall%0d instr", k), in1, 32'h1000_0000);
    end
    cyc(0, 0, 0, 0);
    pres0("stall end", 32'h8);
    check("stall end en", {31'd0, en0}, 32'd1);
    check("stall end addr", addr0, 32'hC);
    cyc(0, 0, 0, 0);
    pres0("after stall", 32'hC);

    // redirect while pc 4 is presented
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0103);
    pres0("redir c3", 32'h4);
    check("redir c3 en", {31'd0, en0}, 32'd0);
    cyc(0, 0, 0, 0);
    check("redir bubble valid", {31'd0, v0}, 32'd0);
    check("redir addr", addr0, 32'h100);
    check("redir en", {31'd0, en0}, 32'd1);

    // redirect and stall together, stall held two more cycles
    cyc(0, 1, 1, 32'h0000_0200);
    pres0("redir target", 32'h100);
    check("rs en", {31'd0, en0}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 0, 0);
      check($sformatf("rs%0d valid", k), {31'd0, v0}, 32'd0);
      check($sformatf("rs%0d addr", k), addr0, 32'h200);
      check($sformatf("rs%0d en", k), {31'd0, en0}, 32'd0);
    end
    cyc(0, 0, 0, 0);
    check("rs fetch valid", {31'd0, v0}, 32'd0);
    check("rs fetch en", {31'd0, en0}, 32'd1);
    check("rs fetch addr", addr0, 32'h200);

    // reset in the middle of a 5-cycle stall
    cyc(0, 1, 0, 0);
    pres0("rstall0", 32'h200);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    pres0("rstall2", 32'h200);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    check("post rst valid", {31'd0, v0}, 32'd0);
    check("post rst pc", pc0, 32'd0);
    check("post rst addr", addr0, 32'd0);
    check("post rst en", {31'd0, en0}, 32'd1);
    check("post rst addr1", addr1, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0);
    pres0("restart", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipeline: owns the program counter, drives a synchronous instruction memory (one-cycle read latency), and presents `{pc, instruction, valid}` to the IF/ID pipeline register directly downstream. It honours a stall from the hazard unit and a redirect (taken branch / jump) from later stages. It keeps a one-entry hold buffer so the presented instruction stays stable across multi-cycle stalls.

## Interface
- `RESET_PC`, default `32'h0000_0000`: byte address of the first fetch after reset; bits [1:0] must be 0.
- `clk` in 1: sole clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hazard unit holds IF and IF/ID; this stage must not advance.
- `redirect_valid` in 1: taken branch/jump this cycle.
- `redirect_pc` in 32: target byte address; bits [1:0] ignored (treated as 0).
- `imem_en` out 1: read enable to instruction memory.
- `imem_addr` out 32: byte address to instruction memory (`= pc_reg`).
- `imem_rdata` in 32: instruction word, valid the cycle after an enabled read.
- `valid_out` out 1: `pc_out`/`instr_out` carry a real instruction.
- `pc_out` out 32: address of presented instruction.
- `pc_plus4_out` out 32: `pc_out + 4` (mod 2^32), link value for jal.
- `instr_out` out 32: presented instruction word.

## Operation
- State:
  - `pc_reg`: next fetch address.
  - `iss_pc`/`iss_valid`: fetch in flight, i.e. presented.
  - `hold_instr`/`use_hold`: stall buffer.
- Outputs:
  - `imem_addr = pc_reg`.
  - `imem_en = ~stall & ~redirect_valid`.
  - `valid_out = iss_valid`; `pc_out = iss_pc`.
  - `instr_out = use_hold ? hold_instr : imem_rdata`.
- Priority each cycle: `rst` > `redirect_valid` > `stall` > advance.
- Redirect:
  - `pc_reg <= {redirect_pc[31:2],2'b00}`; `iss_valid <= 0`; `use_hold <= 0`.
  - No fetch is issued this cycle.
  - Overrides a simultaneous stall.
- Stall (no redirect):
  - `pc_reg`, `iss_pc`, `iss_valid` hold.
  - If `use_hold == 0`: `hold_instr <= imem_rdata`, `use_hold <= 1`.
  - If `use_hold == 1`: the buffer holds.
- Advance (no stall, no redirect):
  - Fetch `pc_reg`.
  - `iss_pc <= pc_reg`; `iss_valid <= 1`.
  - `pc_reg <= pc_reg + 4`; wraps `32'hFFFF_FFFC -> 0`.
  - `use_hold <= 0`.
- All arithmetic is 32-bit unsigned with carry discarded. No misalignment error is reported.

## Timing
- Reset values: `pc_reg = RESET_PC`, `iss_pc = 0`, `iss_valid = 0`, `use_hold = 0`, `hold_instr = 0`. Therefore `valid_out = 0` and `pc_out = 0` during reset. `instr_out` follows `imem_rdata` (don't-care while `valid_out = 0`).
- First cycle after `rst` deasserts (no stall): fetch `RESET_PC`. Next cycle: `valid_out = 1`, `pc_out = RESET_PC`.
- Fetch latency: 1 cycle from `imem_en` to `valid_out` with data.
- Throughput: 1 instruction/cycle with no stall.
- Redirect penalty: redirect in cycle N gives `valid_out = 0` in N+1, target fetched in N+1, target presented in N+2. This assumes no stall in N+1.
- Stall of K cycles starting in cycle S:
  - `valid_out`, `pc_out`, `instr_out` are bit-identical for cycles S..S+K.
  - Instruction memory is not read during the stall.
  - Cycle S+K+1 presents the following instruction.
- Stall while `iss_valid = 0` (e.g. right after redirect or reset): output stays invalid and nothing is fetched.
- Reset mid-stall or mid-redirect: everything returns to reset values in the next cycle. The hold buffer is discarded.

## Test plan
- Reset then free-run, `RESET_PC = 0`, memory word i = `0x1000_0000 + i`: cycles 2..5 present pc 0,4,8,C with instr `0x10000000..0x10000003`; `pc_plus4_out` = pc + 4.
- Stall 3 cycles while pc 8 is presented, memory driving garbage during the stall: `pc_out = 8`, `instr_out = 0x10000002` held for 4 cycles; `imem_en = 0` for 3 cycles; then pc C.
- Redirect to `0x0000_0103` while pc 4 is presented: next cycle `valid_out = 0`, `imem_addr = 0x100`; following cycle `pc_out = 0x100`.
- Redirect and stall asserted in the same cycle, stall held 2 more cycles: redirect wins; `valid_out` stays 0; `imem_addr = target`; fetch occurs on the first non-stall cycle.
- `RESET_PC = 32'hFFFF_FFF8`, free-run: presented pcs `FFFFFFF8`, `FFFFFFFC`, `00000000`; `pc_plus4_out` at `FFFFFFFC` = 0.
- `rst` asserted during a 5-cycle stall: next cycle all outputs at reset values; after release, fetch restarts at `RESET_PC`.
